// File: rtl/sa_r_channel.sv
// Slave-side R channel router: returns read beats to the master that issued the
// matching AR, using an in-order FIFO of destination indices and one output register stage.
module sa_r_channel #(
  parameter int MST_AMT         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_WR_RESP_W = 2,
  parameter int MST_ID_W        = $clog2(MST_AMT),
  parameter int OUTST_DEPTH     = 4
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESET_i,
  input  logic [MST_ID_W-1:0]                   sa_AR_mst_id_i,
  input  logic                                  sa_AR_push_i,
  output logic                                  sa_AR_order_full_o,
  input  logic [TRANS_MST_ID_W-1:0]             s_RID_i,
  input  logic [DATA_WIDTH-1:0]                 s_RDATA_i,
  input  logic [TRANS_WR_RESP_W-1:0]            s_RRESP_i,
  input  logic                                  s_RLAST_i,
  input  logic                                  s_RVALID_i,
  output logic                                  s_RREADY_o,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_RID_o,
  output logic [DATA_WIDTH*MST_AMT-1:0]         dsp_RDATA_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]    dsp_RRESP_o,
  output logic [MST_AMT-1:0]                    dsp_RLAST_o,
  output logic [MST_AMT-1:0]                    dsp_RVALID_o,
  input  logic [MST_AMT-1:0]                    dsp_RREADY_i
);

  localparam int PTR_W = $clog2(OUTST_DEPTH);
  localparam int CNT_W = $clog2(OUTST_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTST_DEPTH);

  logic [MST_ID_W-1:0]        ord_mem [OUTST_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           ord_cnt;
  logic                       ord_full;
  logic                       ord_empty;
  logic                       push_ok;
  logic                       beat_acc;
  logic                       pop;
  logic                       dst_rdy;

  logic                       vld_p1;
  logic [MST_ID_W-1:0]        dst_p1;
  logic [TRANS_MST_ID_W-1:0]  rid_p1;
  logic [DATA_WIDTH-1:0]      data_p1;
  logic [TRANS_WR_RESP_W-1:0] resp_p1;
  logic                       last_p1;

  // Full is judged on the start-of-cycle occupancy, so a pop never frees room for a same-cycle push.
  assign ord_full  = (ord_cnt == FULL_CNT);
  assign ord_empty = (ord_cnt == '0);
  assign dst_rdy   = dsp_RREADY_i[dst_p1];
  assign push_ok   = sa_AR_push_i && !ord_full && !ARESET_i;

  assign s_RREADY_o         = !ARESET_i && !ord_empty && (!vld_p1 || dst_rdy);
  assign sa_AR_order_full_o = ord_full && !ARESET_i;
  assign beat_acc           = s_RVALID_i && s_RREADY_o;
  assign pop                = beat_acc && s_RLAST_i;

  // Order FIFO: pointers wrap naturally, occupancy tracked separately
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ord_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   ord_cnt <= ord_cnt + CNT_W'(1);
        2'b01:   ord_cnt <= ord_cnt - CNT_W'(1);
        default: ord_cnt <= ord_cnt;
      endcase
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (push_ok) ord_mem[wr_ptr] <= sa_AR_mst_id_i;
  end

  // Stage p1: registered beat plus its destination lane
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      vld_p1  <= 1'b0;
      dst_p1  <= '0;
      rid_p1  <= '0;
      data_p1 <= '0;
      resp_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (beat_acc) begin
      vld_p1  <= 1'b1;
      dst_p1  <= ord_mem[rd_ptr];
      rid_p1  <= s_RID_i;
      data_p1 <= s_RDATA_i;
      resp_p1 <= s_RRESP_i;
      last_p1 <= s_RLAST_i;
    end else if (dst_rdy) begin
      vld_p1  <= 1'b0;
    end
  end

  // Payload is broadcast; only the valid is steered to the destination lane.
  for (genvar k = 0; k < MST_AMT; k++) begin : g_lane
    assign dsp_RID_o[k*TRANS_MST_ID_W +: TRANS_MST_ID_W]     = rid_p1;
    assign dsp_RDATA_o[k*DATA_WIDTH +: DATA_WIDTH]           = data_p1;
    assign dsp_RRESP_o[k*TRANS_WR_RESP_W +: TRANS_WR_RESP_W] = resp_p1;
    assign dsp_RLAST_o[k]  = last_p1;
    assign dsp_RVALID_o[k] = vld_p1 && (dst_p1 == MST_ID_W'(k)) && !ARESET_i;
  end

endmodule

// File: tb/tb_sa_r_channel.sv
// Scoreboard bench for sa_r_channel: accepted slave beats are queued with their
// expected lane and compared when they leave on a dispatcher lane.
module tb_sa_r_channel;

  logic        clk = 1'b0;
  logic        ARESET_i;
  logic [0:0]  sa_AR_mst_id_i;
  logic        sa_AR_push_i;
  logic        sa_AR_order_full_o;
  logic [4:0]  s_RID_i;
  logic [31:0] s_RDATA_i;
  logic [1:0]  s_RRESP_i;
  logic        s_RLAST_i;
  logic        s_RVALID_i;
  logic        s_RREADY_o;
  logic [9:0]  dsp_RID_o;
  logic [63:0] dsp_RDATA_o;
  logic [3:0]  dsp_RRESP_o;
  logic [1:0]  dsp_RLAST_o;
  logic [1:0]  dsp_RVALID_o;
  logic [1:0]  dsp_RREADY_i;

  sa_r_channel #(
    .MST_AMT(2), .DATA_WIDTH(32), .TRANS_MST_ID_W(5), .TRANS_WR_RESP_W(2), .OUTST_DEPTH(4)
  ) dut (
    .ACLK_i(clk), .ARESET_i(ARESET_i),
    .sa_AR_mst_id_i(sa_AR_mst_id_i), .sa_AR_push_i(sa_AR_push_i),
    .sa_AR_order_full_o(sa_AR_order_full_o),
    .s_RID_i(s_RID_i), .s_RDATA_i(s_RDATA_i), .s_RRESP_i(s_RRESP_i),
    .s_RLAST_i(s_RLAST_i), .s_RVALID_i(s_RVALID_i), .s_RREADY_o(s_RREADY_o),
    .dsp_RID_o(dsp_RID_o), .dsp_RDATA_o(dsp_RDATA_o), .dsp_RRESP_o(dsp_RRESP_o),
    .dsp_RLAST_o(dsp_RLAST_o), .dsp_RVALID_o(dsp_RVALID_o), .dsp_RREADY_i(dsp_RREADY_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:0]  lane;
    logic [4:0]  rid;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t      sb[$];
  logic [0:0] model_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       acc_prev = 1'b0;
  logic [0:0] acc_lane = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor sits mid low phase, after negedge-driven stimulus has settled.
  always @(negedge clk) begin : mon
    beat_t e;
    logic  was_full;
    #2;
    if (ARESET_i) begin
      model_q.delete();
      sb.delete();
      acc_prev = 1'b0;
    end else begin
      if (acc_prev) chk("vld_latency", {62'd0, dsp_RVALID_o}, acc_lane ? 64'd2 : 64'd1);
      acc_prev = 1'b0;
      if (dsp_RVALID_o != 2'b00) chk("onehot", {63'd0, $onehot(dsp_RVALID_o)}, 64'd1);
      for (int k = 0; k < 2; k++) begin
        if (dsp_RVALID_o[k] && dsp_RREADY_i[k]) begin
          if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            chk("lane", k, {63'd0, e.lane});
            chk("rdata", {32'd0, dsp_RDATA_o[k*32 +: 32]}, {32'd0, e.data});
            chk("rdata_repl", {32'd0, dsp_RDATA_o[(1-k)*32 +: 32]}, {32'd0, e.data});
            chk("rid_resp_last", {56'd0, dsp_RID_o[k*5 +: 5], dsp_RRESP_o[k*2 +: 2], dsp_RLAST_o[k]},
                {56'd0, e.rid, e.resp, e.last});
          end
        end
      end
      was_full = (model_q.size() == 4);
      if (s_RVALID_i && s_RREADY_o) begin
        if (model_q.size() == 0) chk("accept_while_empty", 64'd1, 64'd0);
        else begin
          sb.push_back('{lane: model_q[0], rid: s_RID_i, data: s_RDATA_i, resp: s_RRESP_i, last: s_RLAST_i});
          acc_prev = 1'b1;
          acc_lane = model_q[0];
          if (s_RLAST_i) void'(model_q.pop_front());
        end
      end
      if (sa_AR_push_i && !was_full) model_q.push_back(sa_AR_mst_id_i);
    end
  end

  // All main-thread tasks start and finish 1 time unit after a rising edge.
  task automatic push_ar(input logic [0:0] id);
    sa_AR_push_i   = 1'b1;
    sa_AR_mst_id_i = id;
    @(posedge clk); #1;
    sa_AR_push_i   = 1'b0;
  endtask

  task automatic send_burst(input logic [4:0] rid, input logic [31:0] base, input int n,
                            input logic [1:0] resp, output int stalls);
    logic got;
    int   w;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      s_RVALID_i = 1'b1;
      s_RID_i    = rid;
      s_RDATA_i  = base + i;
      s_RRESP_i  = resp;
      s_RLAST_i  = (i == n - 1);
      got = 1'b0;
      w   = 0;
      while (!got && w < 50) begin
        @(negedge clk); #3;
        if (s_RREADY_o) got = 1'b1;
        else begin stalls++; w++; end
      end
      if (!got) chk("burst_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    s_RVALID_i = 1'b0;
    s_RLAST_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    ARESET_i = 1'b1; sa_AR_push_i = 1'b1; sa_AR_mst_id_i = 1'b1;
    s_RID_i = '0; s_RDATA_i = '0; s_RRESP_i = '0; s_RLAST_i = 1'b0; s_RVALID_i = 1'b1;
    dsp_RREADY_i = 2'b11;

    // Reset: outputs quiet during reset and the first cycle after; pushes ignored
    @(negedge clk); #1;
    chk("rst_rready", {63'd0, s_RREADY_o}, 64'd0);
    chk("rst_rvalid", {62'd0, dsp_RVALID_o}, 64'd0);
    chk("rst_full", {63'd0, sa_AR_order_full_o}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    ARESET_i = 1'b0; sa_AR_push_i = 1'b0; s_RVALID_i = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_rready", {63'd0, s_RREADY_o}, 64'd0);
    chk("post_rst_rvalid", {62'd0, dsp_RVALID_o}, 64'd0);
    chk("post_rst_full", {63'd0, sa_AR_order_full_o}, 64'd0);
    chk("post_rst_rdata", dsp_RDATA_o, 64'd0);
    @(posedge clk); #1;

    // Single 4-beat burst to master 1
    push_ar(1'b1);
    send_burst(5'd3, 32'hA0, 4, 2'b00, st);
    chk("b1_stalls", st, 64'd0);
    s_RVALID_i = 1'b1;
    @(negedge clk); #1;
    chk("b1_fifo_empty", {63'd0, s_RREADY_o}, 64'd0);
    s_RVALID_i = 1'b0;
    idle(2);

    // Back-to-back bursts to masters 0 then 1, no bubble
    push_ar(1'b0);
    push_ar(1'b1);
    send_burst(5'd4, 32'h10, 2, 2'b10, st);
    chk("b2a_stalls", st, 64'd0);
    send_burst(5'd5, 32'h20, 2, 2'b01, st);
    chk("b2b_stalls", st, 64'd0);
    idle(2);

    // Lane 0 stall for three cycles on beat 0xB1
    push_ar(1'b0);
    fork
      begin
        send_burst(5'd6, 32'hB0, 4, 2'b00, st);
        chk("stall_cycles", st, 64'd3);
      end
      begin : stall_drv
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (dsp_RVALID_o[0] && dsp_RDATA_o[31:0] == 32'hB1) seen = 1'b1;
        end
        chk("stall_b1_seen", {63'd0, seen}, 64'd1);
        dsp_RREADY_i[0] = 1'b0;
        repeat (3) begin
          #1;
          chk("stall_rready", {63'd0, s_RREADY_o}, 64'd0);
          chk("stall_rvalid", {62'd0, dsp_RVALID_o}, 64'd1);
          chk("stall_rdata", {32'd0, dsp_RDATA_o[31:0]}, 64'hB1);
          @(negedge clk);
        end
        dsp_RREADY_i[0] = 1'b1;
      end
    join
    idle(2);

    // Fill past depth, then drain with single-beat bursts
    push_ar(1'b0);
    push_ar(1'b1);
    push_ar(1'b0);
    chk("full_at3", {63'd0, sa_AR_order_full_o}, 64'd0);
    push_ar(1'b1);
    chk("full_at4", {63'd0, sa_AR_order_full_o}, 64'd1);
    push_ar(1'b1);
    chk("full_at5", {63'd0, sa_AR_order_full_o}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      send_burst(5'(8 + i), 32'hC0 + 32'(i), 1, 2'b11, st);
      chk("drain_stalls", st, 64'd0);
    end
    s_RVALID_i = 1'b1;
    @(negedge clk); #1;
    chk("drained_rready", {63'd0, s_RREADY_o}, 64'd0);
    chk("drained_full", {63'd0, sa_AR_order_full_o}, 64'd0);
    s_RVALID_i = 1'b0;
    idle(2);

    // RVALID waiting on an empty FIFO while the AR is pushed
    s_RVALID_i = 1'b1; s_RID_i = 5'd12; s_RDATA_i = 32'hE0; s_RRESP_i = 2'b00; s_RLAST_i = 1'b1;
    sa_AR_push_i = 1'b1; sa_AR_mst_id_i = 1'b1;
    @(negedge clk); #1;
    chk("bypass_rready", {63'd0, s_RREADY_o}, 64'd0);
    @(posedge clk); #1;
    sa_AR_push_i = 1'b0;
    @(negedge clk); #1;
    chk("after_push_rready", {63'd0, s_RREADY_o}, 64'd1);
    @(posedge clk); #1;
    s_RVALID_i = 1'b0; s_RLAST_i = 1'b0;
    idle(2);

    // Reset in the middle of a burst
    push_ar(1'b1);
    push_ar(1'b0);
    s_RVALID_i = 1'b1; s_RID_i = 5'd7; s_RDATA_i = 32'hF0; s_RLAST_i = 1'b0;
    @(negedge clk); #1;
    chk("mid_rready", {63'd0, s_RREADY_o}, 64'd1);
    @(posedge clk); #1;
    s_RDATA_i = 32'hF1;
    @(posedge clk); #1;
    ARESET_i = 1'b1; sa_AR_push_i = 1'b1; sa_AR_mst_id_i = 1'b1; s_RDATA_i = 32'hF2;
    @(negedge clk); #1;
    chk("in_rst_rready", {63'd0, s_RREADY_o}, 64'd0);
    chk("in_rst_rvalid", {62'd0, dsp_RVALID_o}, 64'd0);
    @(posedge clk); #1;
    ARESET_i = 1'b0; sa_AR_push_i = 1'b0; s_RVALID_i = 1'b0;
    @(negedge clk); #1;
    chk("rst2_rvalid", {62'd0, dsp_RVALID_o}, 64'd0);
    chk("rst2_rready", {63'd0, s_RREADY_o}, 64'd0);
    chk("rst2_full", {63'd0, sa_AR_order_full_o}, 64'd0);
    chk("rst2_rdata", dsp_RDATA_o, 64'd0);
    @(posedge clk); #1;
    push_ar(1'b0);
    send_burst(5'd9, 32'hD0, 2, 2'b00, st);
    chk("post_rst_stalls", st, 64'd0);
    idle(3);

    chk("sb_left", sb.size(), 64'd0);
    chk("order_left", model_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
